ctrl_seq_unit: RTL and testbench

Parametrised, registered successor to the ID-stage control decoder. It decodes mode/opCode/S into the EXE control word and registers it into a valid/ready output slot. It inserts bubbles on hazard or condition failure and splits base-writeback loads/stores into two micro-ops via a small FSM. It also keeps saturating issue and bubble counters, and sits between instruction decode and the ID/EX register.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_decode.sv | 57 +++++
 rtl/ctrl_seq_unit.sv | 132 +++++++++++++
 tb/tb_ctrl_seq_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the registered ID-stage control sequencer:
// mode/opcode encodings, ALU command codes and the EXE control word layout.
package ctrl_pkg;

    localparam logic [1:0] MODE_CALC    = 2'b00;
    localparam logic [1:0] MODE_LDST    = 2'b01;
    localparam logic [1:0] MODE_BRANCH  = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_UOP2 = 1'b1
    } seq_state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef struct packed {
        logic [3:0] exeCmd;
        logic       memRead;
        logic       memWrite;
        logic       wbEn;
        logic       branch;
        logic       sOut;
        logic       wbSel;
        logic       uopIdx;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_ZERO = '0;

    // Second micro-op of a base-writeback load/store: Rn <= Rn + offset.
    function automatic ctrl_word_t base_wb_uop();
        ctrl_word_t w;
        w        = CTRL_ZERO;
        w.exeCmd = EXE_ADD;
        w.wbEn   = 1'b1;
        w.wbSel  = 1'b1;
        w.uopIdx = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational decode of mode/opCode/S into the first micro-op's
// control word (wbSel and uopIdx are always 0 here).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] op_code,
    input  logic       s_in,
    output ctrl_word_t word
);

    always_comb begin
        word = CTRL_ZERO;
        case (mode)
            MODE_CALC: begin
                word.wbEn = 1'b1;
                word.sOut = s_in;
                case (op_code)
                    OP_MOV: word.exeCmd = EXE_MOV;
                    OP_MVN: word.exeCmd = EXE_MVN;
                    OP_ADD: word.exeCmd = EXE_ADD;
                    OP_ADC: word.exeCmd = EXE_ADC;
                    OP_SUB: word.exeCmd = EXE_SUB;
                    OP_SBC: word.exeCmd = EXE_SBC;
                    OP_AND: word.exeCmd = EXE_AND;
                    OP_ORR: word.exeCmd = EXE_ORR;
                    OP_EOR: word.exeCmd = EXE_EOR;
                    // Compares only update flags, never a register.
                    OP_CMP: begin
                        word.exeCmd = EXE_SUB;
                        word.sOut   = 1'b1;
                        word.wbEn   = 1'b0;
                    end
                    OP_TST: begin
                        word.exeCmd = EXE_AND;
                        word.sOut   = 1'b1;
                        word.wbEn   = 1'b0;
                    end
                    default: word = CTRL_ZERO;
                endcase
            end
            MODE_LDST: begin
                word.exeCmd   = EXE_ADD;
                word.memRead  = s_in;
                word.wbEn     = s_in;
                word.memWrite = ~s_in;
            end
            MODE_BRANCH: begin
                word.branch = 1'b1;
            end
            default: begin
                word.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Registered control sequencer: decodes into a valid/ready output slot,
// inserts bubbles, splits base-writeback load/stores and counts issues/bubbles.
module ctrl_seq_unit
    import ctrl_pkg::*;
#(
    parameter int EXE_CMD_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [1:0]           mode,
    input  logic [3:0]           opCode,
    input  logic                 sIn,
    input  logic                 wbBase,
    input  logic                 condPass,
    input  logic                 hazard,
    input  logic                 flush,
    input  logic                 outReady,
    output logic                 outValid,
    output logic [EXE_CMD_W-1:0] exeCmd,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 wbEn,
    output logic                 branch,
    output logic                 sOut,
    output logic                 wbSel,
    output logic                 uopIdx,
    output logic                 illegal,
    output logic [CNT_W-1:0]     issueCnt,
    output logic [CNT_W-1:0]     bubbleCnt
);

    seq_state_t       state;
    seq_state_t       state_next;
    ctrl_word_t       slot;
    ctrl_word_t       slot_next;
    ctrl_word_t       dec_word;
    logic             slot_valid;
    logic             valid_next;
    logic             adv;
    logic             accept;
    logic             issue_inc;
    logic             bubble_inc;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    ctrl_decode u_decode (
        .mode    (mode),
        .op_code (opCode),
        .s_in    (sIn),
        .word    (dec_word)
    );

    assign adv     = ~slot_valid | outReady;
    assign inReady = adv & ~hazard & ~flush & (state == ST_IDLE);
    assign accept  = inValid & inReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over everything; a pending second micro-op beats new input.
    always_comb begin
        state_next = state;
        valid_next = slot_valid;
        slot_next  = slot;
        issue_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            slot_next  = CTRL_ZERO;
        end else if (adv) begin
            if (state == ST_UOP2) begin
                valid_next = 1'b1;
                slot_next  = base_wb_uop();
                issue_inc  = 1'b1;
                state_next = ST_IDLE;
            end else if (accept && condPass) begin
                valid_next = 1'b1;
                slot_next  = dec_word;
                issue_inc  = 1'b1;
                if (mode == MODE_LDST && wbBase) begin
                    state_next = ST_UOP2;
                end
            end else begin
                // Condition-failed accepts and hazard-blocked inputs both bubble.
                valid_next = 1'b0;
                slot_next  = CTRL_ZERO;
                bubble_inc = inValid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
            slot       <= CTRL_ZERO;
            issue_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            slot_valid <= valid_next;
            slot       <= slot_next;
            if (issue_inc && (issue_cnt != {CNT_W{1'b1}})) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign outValid  = slot_valid;
    assign exeCmd    = EXE_CMD_W'(slot.exeCmd);
    assign memRead   = slot.memRead;
    assign memWrite  = slot.memWrite;
    assign wbEn      = slot.wbEn;
    assign branch    = slot.branch;
    assign sOut      = slot.sOut;
    assign wbSel     = slot.wbSel;
    assign uopIdx    = slot.uopIdx;
    assign illegal   = slot.illegal;
    assign issueCnt  = issue_cnt;
    assign bubbleCnt = bubble_cnt;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Directed bench for ctrl_seq_unit with a cycle-level reference model and a
// second 2-bit-counter instance sharing the same stimulus to exercise saturation.
module tb_ctrl_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, wb_base, cond_pass, hazard, flush, out_ready, s_in;
    logic [1:0] mode;
    logic [3:0] op_code;

    logic        in_ready, out_valid, mem_read, mem_write, wb_en, branch, s_out, wb_sel, uop_idx, illegal;
    logic [3:0]  exe_cmd;
    logic [15:0] issue_cnt, bubble_cnt;

    logic       in_ready2, out_valid2, mem_read2, mem_write2, wb_en2, branch2, s_out2, wb_sel2, uop_idx2, illegal2;
    logic [3:0] exe_cmd2;
    logic [1:0] issue_cnt2, bubble_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ctrl_seq_unit #(.EXE_CMD_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready),
        .mode(mode), .opCode(op_code), .sIn(s_in), .wbBase(wb_base),
        .condPass(cond_pass), .hazard(hazard), .flush(flush), .outReady(out_ready),
        .outValid(out_valid), .exeCmd(exe_cmd), .memRead(mem_read), .memWrite(mem_write),
        .wbEn(wb_en), .branch(branch), .sOut(s_out), .wbSel(wb_sel), .uopIdx(uop_idx),
        .illegal(illegal), .issueCnt(issue_cnt), .bubbleCnt(bubble_cnt)
    );

    ctrl_seq_unit #(.EXE_CMD_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready2),
        .mode(mode), .opCode(op_code), .sIn(s_in), .wbBase(wb_base),
        .condPass(cond_pass), .hazard(hazard), .flush(flush), .outReady(out_ready),
        .outValid(out_valid2), .exeCmd(exe_cmd2), .memRead(mem_read2), .memWrite(mem_write2),
        .wbEn(wb_en2), .branch(branch2), .sOut(s_out2), .wbSel(wb_sel2), .uopIdx(uop_idx2),
        .illegal(illegal2), .issueCnt(issue_cnt2), .bubbleCnt(bubble_cnt2)
    );

    // ALU command per calc opcode; -1 marks opcodes that decode to a NOP.
    int calc_table [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    // Word layout: {cmd[3:0], memRead, memWrite, wbEn, branch, sOut, wbSel, uopIdx, illegal}
    function automatic logic [11:0] ref_decode(input logic [1:0] md, input logic [3:0] op, input logic s);
        int         c;
        logic [3:0] cmd;
        logic       is_cmp;
        case (md)
            2'b00: begin
                c = calc_table[op];
                if (c < 0) return 12'h000;
                cmd    = 4'(c);
                is_cmp = (op == 4'b1000) || (op == 4'b1010);
                if (is_cmp) return {cmd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
                return {cmd, 1'b0, 1'b0, 1'b1, 1'b0, s, 3'b000};
            end
            2'b01:   return {4'd2, s, ~s, s, 1'b0, 1'b0, 3'b000};
            2'b10:   return {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
            default: return {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001};
        endcase
    endfunction

    localparam logic [11:0] UOP1_WORD = {4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic        m_valid;
    logic [11:0] m_word;
    logic        m_owed;
    int          m_issue;
    int          m_bubble;

    // The model thinks in terms of "a second micro-op is owed" and plain counts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_word = '0; m_owed = 1'b0; m_issue = 0; m_bubble = 0;
        end else if (flush) begin
            m_valid = 1'b0; m_word = '0; m_owed = 1'b0;
        end else if (!m_valid || out_ready) begin
            if (m_owed) begin
                m_valid = 1'b1; m_word = UOP1_WORD; m_owed = 1'b0; m_issue++;
            end else if (in_valid && !hazard && cond_pass) begin
                m_valid = 1'b1; m_word = ref_decode(mode, op_code, s_in); m_issue++;
                m_owed  = (mode == 2'b01) && wb_base;
            end else begin
                m_valid = 1'b0; m_word = '0;
                if (in_valid) m_bubble++;
            end
        end
    end

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Per-cycle comparison against the model, sampled 2ns after the rising edge.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check_output("model outValid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check_output("model word", 32'({exe_cmd, mem_read, mem_write, wb_en, branch, s_out, wb_sel, uop_idx, illegal}), 32'(m_word));
            end
            check_output("model inReady", 32'(in_ready), 32'((!m_valid || out_ready) && !hazard && !flush && !m_owed));
            check_output("model issueCnt", 32'(issue_cnt), 32'(m_issue));
            check_output("model bubbleCnt", 32'(bubble_cnt), 32'(m_bubble));
            check_output("sat issueCnt", 32'(issue_cnt2), 32'(sat3(m_issue)));
            check_output("sat bubbleCnt", 32'(bubble_cnt2), 32'(sat3(m_bubble)));
        end
    end

    task automatic apply_stimulus(input logic v, input logic [1:0] md, input logic [3:0] op, input logic s,
                                  input logic wb, input logic cp, input logic hz, input logic fl, input logic ordy);
        @(negedge clk);
        in_valid = v; mode = md; op_code = op; s_in = s; wb_base = wb;
        cond_pass = cp; hazard = hz; flush = fl; out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; mode = 0; op_code = 0; s_in = 0; wb_base = 0;
        cond_pass = 0; hazard = 0; flush = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #2;
        check_output("reset outValid", 32'(out_valid), 0);
        check_output("reset exeCmd", 32'(exe_cmd), 0);
        check_output("reset issueCnt", 32'(issue_cnt), 0);
        check_output("reset bubbleCnt", 32'(bubble_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD, S=1
        apply_stimulus(1, 2'b00, 4'b0100, 1, 0, 1, 0, 0, 1);
        #1 check_output("ADD inReady", 32'(in_ready), 1);
        step();
        check_output("ADD outValid", 32'(out_valid), 1);
        check_output("ADD exeCmd", 32'(exe_cmd), 2);
        check_output("ADD wbEn/sOut", 32'({wb_en, s_out}), 32'b11);
        check_output("ADD issueCnt", 32'(issue_cnt), 1);

        // LDR with base writeback
        apply_stimulus(1, 2'b01, 4'b0000, 1, 1, 1, 0, 0, 1);
        step();
        check_output("LDR uop0 ctrl", 32'({mem_read, wb_en, wb_sel, uop_idx}), 32'b1100);
        check_output("LDR uop0 inReady", 32'(in_ready), 0);
        apply_stimulus(0, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 1);
        step();
        check_output("LDR uop1 exeCmd", 32'(exe_cmd), 2);
        check_output("LDR uop1 ctrl", 32'({mem_read, wb_en, wb_sel, uop_idx}), 32'b0111);
        check_output("LDR issueCnt", 32'(issue_cnt), 3);
        apply_stimulus(0, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 1);
        step();

        // CMP with failed condition, then hazard-blocked input
        apply_stimulus(1, 2'b00, 4'b1010, 0, 0, 0, 0, 0, 1);
        #1 check_output("CMP inReady", 32'(in_ready), 1);
        step();
        check_output("CMP bubble outValid", 32'(out_valid), 0);
        check_output("CMP bubbleCnt", 32'(bubble_cnt), 1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 2'b00, 4'b0100, 1, 0, 1, 1, 0, 1);
            #1 check_output("hazard inReady", 32'(in_ready), 0);
            step();
        end
        check_output("hazard bubbleCnt", 32'(bubble_cnt), 4);

        // MVN held while downstream stalls
        apply_stimulus(1, 2'b00, 4'b1111, 0, 0, 1, 0, 0, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 2'b00, 4'b0100, 1, 0, 1, 0, 0, 0);
            #1 check_output("stall inReady", 32'(in_ready), 0);
            step();
            check_output("stall exeCmd", 32'(exe_cmd), 9);
        end
        check_output("stall issueCnt", 32'(issue_cnt), 4);
        check_output("stall bubbleCnt", 32'(bubble_cnt), 4);
        apply_stimulus(1, 2'b00, 4'b0100, 1, 0, 1, 0, 0, 1);
        step();
        check_output("post-stall issueCnt", 32'(issue_cnt), 5);

        // STR with base writeback, flushed during uop0
        apply_stimulus(1, 2'b01, 4'b0000, 0, 1, 1, 0, 0, 1);
        step();
        check_output("STR uop0 memWrite", 32'(mem_write), 1);
        apply_stimulus(1, 2'b00, 4'b0100, 1, 0, 1, 0, 1, 1);
        #1 check_output("flush inReady", 32'(in_ready), 0);
        step();
        check_output("flush outValid", 32'(out_valid), 0);
        check_output("flush controls", 32'({exe_cmd, mem_read, mem_write, wb_en, branch, s_out, wb_sel, uop_idx, illegal}), 0);
        apply_stimulus(0, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 1);
        #1 check_output("post-flush inReady", 32'(in_ready), 1);
        step();
        check_output("no uop1 after flush", 32'(out_valid), 0);
        check_output("flush issueCnt", 32'(issue_cnt), 6);

        // Illegal, branch, undefined calc opcode, TST, plain LDR
        apply_stimulus(1, 2'b11, 4'b0100, 1, 0, 1, 0, 0, 1);
        step();
        check_output("illegal word", 32'({out_valid, exe_cmd, mem_read, mem_write, wb_en, branch, s_out, wb_sel, uop_idx, illegal}), 32'h1001);
        apply_stimulus(1, 2'b10, 4'b0000, 1, 0, 1, 0, 0, 1);
        step();
        check_output("branch bit", 32'({branch, wb_en, exe_cmd}), 32'h20);
        apply_stimulus(1, 2'b00, 4'b0011, 1, 0, 1, 0, 0, 1);
        step();
        check_output("NOP word", 32'({out_valid, exe_cmd, wb_en, s_out}), 32'h40);
        apply_stimulus(1, 2'b00, 4'b1000, 0, 0, 1, 0, 0, 1);
        step();
        check_output("TST word", 32'({exe_cmd, wb_en, s_out}), 32'h19);
        apply_stimulus(1, 2'b01, 4'b0000, 1, 0, 1, 0, 0, 1);
        step();
        check_output("LDR no-wb", 32'({mem_read, wb_en, uop_idx}), 32'b110);

        // Back-to-back throughput: EOR, SUB, SBC, AND, ORR, MOV, ADC
        begin
            logic [3:0] ops [7] = '{4'b0001, 4'b0010, 4'b0110, 4'b0000, 4'b1100, 4'b1101, 4'b0101};
            for (int i = 0; i < 7; i++) begin
                apply_stimulus(1, 2'b00, ops[i], 1, 0, 1, 0, 0, 1);
                #1 check_output("streaming inReady", 32'(in_ready), 1);
                step();
            end
        end
        check_output("stream issueCnt", 32'(issue_cnt), 18);
        check_output("sat issue literal", 32'(issue_cnt2), 3);
        check_output("sat bubble literal", 32'(bubble_cnt2), 3);

        // Asynchronous reset while a second micro-op is owed
        apply_stimulus(1, 2'b01, 4'b0000, 1, 1, 1, 0, 0, 1);
        step();
        check_output("pre-reset uop0", 32'({out_valid, mem_read}), 32'b11);
        #1 rst_n = 1'b0;
        #1;
        check_output("async reset slot", 32'({out_valid, exe_cmd, mem_read, mem_write, wb_en, branch, s_out, wb_sel, uop_idx, illegal}), 0);
        check_output("async reset issueCnt", 32'(issue_cnt), 0);
        check_output("async reset sat issueCnt", 32'(issue_cnt2), 0);
        apply_stimulus(0, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 1);
        rst_n = 1'b1;
        #1 check_output("post-reset inReady", 32'(in_ready), 1);
        step();
        check_output("no uop1 after reset", 32'(out_valid), 0);

        repeat (3) step();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
